mem_lsu_seq: RTL and testbench

//  Parametrised memory-stage load/store unit between execute and writeback. Runs single LDR/STR
//  (word/byte, pre/post index, up/down, base writeback) and full LDM/STM block transfers (IA/IB/DA/DB,

---
 rtl/mem_lsu_seq_pkg.sv | 31 +++
 rtl/lsu_prio_enc.sv | 27 ++
 rtl/mem_lsu_seq.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_mem_lsu_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_seq_pkg.sv
// Shared decode constants, FSM state type and instruction-class helpers for the memory-stage LSU.
package mem_lsu_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StXfer,
      StSwb,
      StMulti,
      StMwb
   } lsu_state_e;

   localparam int unsigned InsnP = 24;
   localparam int unsigned InsnU = 23;
   localparam int unsigned InsnB = 22;
   localparam int unsigned InsnW = 21;
   localparam int unsigned InsnL = 20;
   localparam int unsigned InsnRn = 16;
   localparam int unsigned InsnRd = 12;

   localparam logic [1:0] LdrStrPat = 2'b01;
   localparam logic [2:0] LdmStmPat = 3'b100;

   function automatic logic is_ldrstr(input logic [31:0] insn);
      return insn[27:26] == LdrStrPat;
   endfunction

   function automatic logic is_ldmstm(input logic [31:0] insn);
      return insn[27:25] == LdmStmPat;
   endfunction

endpackage

// File: rtl/lsu_prio_enc.sv
// Lowest-set-bit priority encoder for the block-transfer register list.
module lsu_prio_enc #(
   parameter int unsigned NREG = 16,
   parameter int unsigned RW   = $clog2(NREG)
) (
   input  logic [NREG-1:0] list_i,
   output logic [RW-1:0]   idx_o,
   output logic [NREG-1:0] clr_o,
   output logic            vld_o
);

   // Scan from the top so the last hit is the lowest index.
   always_comb begin
      idx_o = '0;
      clr_o = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (list_i[i]) begin
            idx_o    = RW'(i);
            clr_o    = '0;
            clr_o[i] = 1'b1;
         end
      end
   end

   assign vld_o = |list_i;

endmodule

// File: rtl/mem_lsu_seq.sv
// Memory-stage load/store unit: single LDR/STR and LDM/STM block transfers over a shared bus,
// with one regfile read port for store data and one registered writeback port.
module mem_lsu_seq
   import mem_lsu_seq_pkg::*;
#(
   parameter int unsigned DW   = 32,
   parameter int unsigned AW   = 32,
   parameter int unsigned NREG = 16,
   parameter int unsigned RW   = $clog2(NREG)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic [AW-1:0]     busaddr_o,
   output logic              rd_req_o,
   output logic              wr_req_o,
   output logic [DW/8-1:0]   wr_be_o,
   output logic [DW-1:0]     wr_data_o,
   input  logic              rw_wait_i,
   input  logic [DW-1:0]     rd_data_i,
   output logic [RW-1:0]     st_read_o,
   input  logic [DW-1:0]     st_data_i,
   input  logic              inbubble_i,
   input  logic [31:0]       pc_i,
   input  logic [31:0]       insn_i,
   input  logic [AW-1:0]     op0_i,
   input  logic [AW-1:0]     op1_i,
   input  logic              write_reg_i,
   input  logic [RW-1:0]     write_num_i,
   input  logic [DW-1:0]     write_data_i,
   output logic              outstall_o,
   output logic              outbubble_o,
   output logic [31:0]       outpc_o,
   output logic [31:0]       outinsn_o,
   output logic              out_write_reg_o,
   output logic [RW-1:0]     out_write_num_o,
   output logic [DW-1:0]     out_write_data_o
);

   localparam int unsigned NB = DW / 8;
   localparam int unsigned LB = $clog2(NB);

   function automatic logic [RW:0] popcnt(input logic [NREG-1:0] v);
      logic [RW:0] c;
      c = '0;
      for (int i = 0; i < NREG; i++) begin
         c = c + {{RW{1'b0}}, v[i]};
      end
      return c;
   endfunction

   lsu_state_e      state_q, state_d;
   logic [NREG-1:0] list_q, list_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            outbubble_q, outbubble_d;
   logic            wb_q, wb_d;
   logic [RW-1:0]   wb_num_q, wb_num_d;
   logic [DW-1:0]   wb_data_q, wb_data_d;
   logic [31:0]     outpc_q, outinsn_q;

   logic            is_single, is_block;
   logic            bit_p, bit_u, bit_b, bit_w, bit_l;
   logic [RW-1:0]   rd, rn;
   logic [NREG-1:0] list_in, cur_list, cur_clr, list_rest;
   logic [RW-1:0]   cur_idx;
   logic            cur_vld;
   logic [AW-1:0]   ea, saddr, span, blk_start, blk_wb, cur_addr;
   logic [LB-1:0]   lane;
   logic [DW-1:0]   rot, ld_val;
   logic            single_act, block_act, last_c;
   logic            unused_insn;

   assign is_single = !inbubble_i && is_ldrstr(insn_i);
   assign is_block  = !inbubble_i && is_ldmstm(insn_i);
   assign bit_p     = insn_i[InsnP];
   assign bit_u     = insn_i[InsnU];
   assign bit_b     = insn_i[InsnB];
   assign bit_w     = insn_i[InsnW];
   assign bit_l     = insn_i[InsnL];
   assign rd        = insn_i[InsnRd +: RW];
   assign rn        = insn_i[InsnRn +: RW];
   assign list_in   = insn_i[NREG-1:0];
   assign unused_insn = ^insn_i[31:28];

   assign ea    = bit_u ? op0_i + op1_i : op0_i - op1_i;
   assign saddr = bit_p ? ea : op0_i;
   assign lane  = saddr[LB-1:0];
   assign span  = AW'(popcnt(list_in)) << LB;
   assign blk_wb = bit_u ? op0_i + span : op0_i - span;

   always_comb begin
      case ({bit_p, bit_u})
         2'b01:   blk_start = op0_i;
         2'b11:   blk_start = op0_i + AW'(NB);
         2'b00:   blk_start = op0_i - span + AW'(NB);
         default: blk_start = op0_i - span;
      endcase
   end

   // Later beats come from the latched list/address; the entry beat comes straight from the inputs.
   assign cur_list = (state_q == StMulti) ? list_q : list_in;
   assign cur_addr = (state_q == StMulti) ? addr_q : blk_start;

   lsu_prio_enc #(
      .NREG (NREG),
      .RW   (RW)
   ) u_prio_enc (
      .list_i (cur_list),
      .idx_o  (cur_idx),
      .clr_o  (cur_clr),
      .vld_o  (cur_vld)
   );

   assign list_rest = cur_list & ~cur_clr;

   always_comb begin
      logic [LB-1:0] src;
      rot = '0;
      src = '0;
      for (int i = 0; i < NB; i++) begin
         src = LB'(i) + lane;
         rot[8*i +: 8] = rd_data_i[8*src +: 8];
      end
   end

   assign ld_val = bit_b ? {{(DW-8){1'b0}}, rot[7:0]} : rot;

   assign single_act = (state_q == StXfer) || (state_q == StIdle && is_single);
   assign block_act  = (state_q == StMulti) || (state_q == StIdle && is_block && cur_vld);

   always_comb begin
      busaddr_o = '0;
      rd_req_o  = 1'b0;
      wr_req_o  = 1'b0;
      wr_be_o   = '0;
      wr_data_o = '0;
      st_read_o = '0;
      if (single_act) begin
         busaddr_o = {saddr[AW-1:LB], {LB{1'b0}}};
         rd_req_o  = bit_l;
         wr_req_o  = !bit_l;
         if (!bit_l) begin
            st_read_o = rd;
            if (bit_b) begin
               wr_data_o = {NB{st_data_i[7:0]}};
               wr_be_o   = NB'(1) << lane;
            end else begin
               wr_data_o = st_data_i;
               wr_be_o   = '1;
            end
         end
      end else if (block_act) begin
         busaddr_o = {cur_addr[AW-1:LB], {LB{1'b0}}};
         rd_req_o  = bit_l;
         wr_req_o  = !bit_l;
         if (!bit_l) begin
            st_read_o = cur_idx;
            wr_data_o = st_data_i;
            wr_be_o   = '1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      list_d      = list_q;
      addr_d      = addr_q;
      outbubble_d = 1'b1;
      wb_d        = 1'b0;
      wb_num_d    = wb_num_q;
      wb_data_d   = wb_data_q;
      outstall_o  = 1'b0;
      last_c      = 1'b0;
      if (single_act) begin
         if (rw_wait_i) begin
            outstall_o = 1'b1;
            state_d    = StXfer;
         end else begin
            if (bit_l) begin
               wb_d      = 1'b1;
               wb_num_d  = rd;
               wb_data_d = ld_val;
            end
            if (bit_w || !bit_p) begin
               outstall_o = 1'b1;
               state_d    = StSwb;
            end else begin
               last_c = 1'b1;
            end
         end
      end else if (block_act) begin
         if (state_q == StIdle) begin
            list_d = list_in;
            addr_d = blk_start;
         end
         if (rw_wait_i) begin
            outstall_o = 1'b1;
            state_d    = StMulti;
         end else begin
            if (bit_l) begin
               wb_d      = 1'b1;
               wb_num_d  = cur_idx;
               wb_data_d = rd_data_i;
            end
            list_d = list_rest;
            addr_d = cur_addr + AW'(NB);
            if (|list_rest) begin
               outstall_o = 1'b1;
               state_d    = StMulti;
            end else if (bit_w) begin
               outstall_o = 1'b1;
               state_d    = StMwb;
            end else begin
               last_c = 1'b1;
            end
         end
      end else begin
         unique case (state_q)
            StSwb: begin
               last_c = 1'b1;
               // A load into the base register keeps the loaded value.
               if (!(bit_l && rd == rn)) begin
                  wb_d      = 1'b1;
                  wb_num_d  = rn;
                  wb_data_d = DW'(ea);
               end
            end
            StMwb: begin
               last_c = 1'b1;
               if (!(bit_l && list_in[rn])) begin
                  wb_d      = 1'b1;
                  wb_num_d  = rn;
                  wb_data_d = DW'(blk_wb);
               end
            end
            default: begin
               if (is_block) begin
                  last_c = 1'b1;
                  if (bit_w) begin
                     wb_d      = 1'b1;
                     wb_num_d  = rn;
                     wb_data_d = DW'(blk_wb);
                  end
               end else begin
                  wb_d        = write_reg_i;
                  wb_num_d    = write_num_i;
                  wb_data_d   = write_data_i;
                  outbubble_d = inbubble_i;
               end
            end
         endcase
      end
      if (last_c) begin
         outbubble_d = 1'b0;
         state_d     = StIdle;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         list_q      <= '0;
         addr_q      <= '0;
         outbubble_q <= 1'b1;
         wb_q        <= 1'b0;
         wb_num_q    <= '0;
         wb_data_q   <= '0;
         outpc_q     <= '0;
         outinsn_q   <= '0;
      end else begin
         state_q     <= state_d;
         list_q      <= list_d;
         addr_q      <= addr_d;
         outbubble_q <= outbubble_d;
         wb_q        <= wb_d;
         wb_num_q    <= wb_num_d;
         wb_data_q   <= wb_data_d;
         outpc_q     <= pc_i;
         outinsn_q   <= insn_i;
      end
   end

   assign outbubble_o      = outbubble_q;
   assign outpc_o          = outpc_q;
   assign outinsn_o        = outinsn_q;
   assign out_write_reg_o  = wb_q;
   assign out_write_num_o  = wb_num_q;
   assign out_write_data_o = wb_data_q;

endmodule

// File: tb/tb_mem_lsu_seq.sv
// Scoreboard bench for mem_lsu_seq: directed instructions push expected bus beats and writebacks.
module tb_mem_lsu_seq;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [3:0]  be;
      logic [31:0] data;
      logic [3:0]  sr;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] busaddr;
   logic        rd_req, wr_req;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic        rw_wait;
   logic [31:0] rd_data;
   logic [3:0]  st_read;
   logic [31:0] st_data;
   logic        inbubble;
   logic [31:0] pc, insn, op0, op1;
   logic        write_reg;
   logic [3:0]  write_num;
   logic [31:0] write_data;
   logic        outstall, outbubble;
   logic [31:0] outpc, outinsn;
   logic        out_write_reg;
   logic [3:0]  out_write_num;
   logic [31:0] out_write_data;

   logic [31:0] rf [16];
   logic        rd_mode;
   logic [31:0] rd_fix;
   int          checks = 0;
   int          errors = 0;
   beat_t       bq[$];
   logic [35:0] wq[$];
   beat_t       mon_b;
   logic [35:0] mon_w;
   logic [69:0] held;
   logic        held_v = 1'b0;
   int          st;

   always #5 clk = ~clk;

   assign st_data = rf[st_read];
   assign rd_data = rd_mode ? (32'hD000_0000 | busaddr) : rd_fix;

   mem_lsu_seq #(
      .DW   (32),
      .AW   (32),
      .NREG (16),
      .RW   (4)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .busaddr_o        (busaddr),
      .rd_req_o         (rd_req),
      .wr_req_o         (wr_req),
      .wr_be_o          (wr_be),
      .wr_data_o        (wr_data),
      .rw_wait_i        (rw_wait),
      .rd_data_i        (rd_data),
      .st_read_o        (st_read),
      .st_data_i        (st_data),
      .inbubble_i       (inbubble),
      .pc_i             (pc),
      .insn_i           (insn),
      .op0_i            (op0),
      .op1_i            (op1),
      .write_reg_i      (write_reg),
      .write_num_i      (write_num),
      .write_data_i     (write_data),
      .outstall_o       (outstall),
      .outbubble_o      (outbubble),
      .outpc_o          (outpc),
      .outinsn_o        (outinsn),
      .out_write_reg_o  (out_write_reg),
      .out_write_num_o  (out_write_num),
      .out_write_data_o (out_write_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_beat(input logic [31:0] a, input logic w, input logic [3:0] be,
                            input logic [31:0] d, input logic [3:0] sr);
      beat_t b;
      b.addr = a;
      b.wr   = w;
      b.be   = be;
      b.data = d;
      b.sr   = sr;
      bq.push_back(b);
   endtask

   task automatic push_wb(input logic [3:0] n, input logic [31:0] d);
      wq.push_back({n, d});
   endtask

   // Presents one instruction, inserting nwait bus-wait cycles at its start, until outstall drops.
   task automatic run_insn(input logic [31:0] i_insn, input logic [31:0] i_op0,
                           input logic [31:0] i_op1, input int nwait, output int stalls);
      bit done;
      done     = 1'b0;
      stalls   = 0;
      pc       = pc + 4;
      insn     = i_insn;
      op0      = i_op0;
      op1      = i_op1;
      inbubble = 1'b0;
      rw_wait  = (nwait > 0);
      for (int c = 1; c <= 40 && !done; c++) begin
         @(negedge clk);
         if (outstall) stalls++;
         else done = 1'b1;
         @(posedge clk);
         #1;
         rw_wait = (c < nwait);
      end
      inbubble = 1'b1;
      insn     = 32'h0;
      rw_wait  = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL insn_timeout: insn %h still stalling after 40 cycles", i_insn);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (out_write_reg) begin
            checks++;
            if (wq.size() == 0) begin
               errors++;
               $display("FAIL wb_unexpected: got r%0d=%h, none expected", out_write_num,
                        out_write_data);
            end else begin
               mon_w = wq.pop_front();
               if ({out_write_num, out_write_data} !== mon_w) begin
                  errors++;
                  $display("FAIL wb_value: got r%0d=%h expected r%0d=%h", out_write_num,
                           out_write_data, mon_w[35:32], mon_w[31:0]);
               end
            end
         end
         if ((rd_req || wr_req) && !rw_wait) begin
            checks++;
            if (bq.size() == 0) begin
               errors++;
               $display("FAIL bus_unexpected: got addr %h rd %b wr %b, none expected", busaddr,
                        rd_req, wr_req);
            end else begin
               mon_b = bq.pop_front();
               if (busaddr !== mon_b.addr || wr_req !== mon_b.wr || rd_req !== !mon_b.wr ||
                   (mon_b.wr && (wr_be !== mon_b.be || wr_data !== mon_b.data ||
                                 st_read !== mon_b.sr))) begin
                  errors++;
                  $display("FAIL bus_beat: got addr %h wr %b be %b data %h st_read %0d expected addr %h wr %b be %b data %h st_read %0d",
                           busaddr, wr_req, wr_be, wr_data, st_read, mon_b.addr, mon_b.wr,
                           mon_b.be, mon_b.data, mon_b.sr);
               end
            end
         end
         if (held_v && (rd_req || wr_req)) begin
            checks++;
            if ({busaddr, rd_req, wr_req, wr_be, wr_data} !== held) begin
               errors++;
               $display("FAIL bus_hold: got %h expected %h", {busaddr, rd_req, wr_req, wr_be,
                        wr_data}, held);
            end
         end
         held   = {busaddr, rd_req, wr_req, wr_be, wr_data};
         held_v = (rd_req || wr_req) && rw_wait;
      end else begin
         held_v = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      inbubble   = 1'b1;
      pc         = 32'h0;
      insn       = 32'h0;
      op0        = 32'h0;
      op1        = 32'h0;
      write_reg  = 1'b0;
      write_num  = 4'h0;
      write_data = 32'h0;
      rw_wait    = 1'b0;
      rd_mode    = 1'b0;
      rd_fix     = 32'h0;
      for (int i = 0; i < 16; i++) rf[i] = 32'hC0DE_0000 + i;
      rf[5] = 32'h0000_005A;

      @(negedge clk);
      chk("rst_outbubble", outbubble, 1);
      chk("rst_out_write_reg", out_write_reg, 0);
      chk("rst_out_write_num", out_write_num, 0);
      chk("rst_out_write_data", out_write_data, 0);
      chk("rst_outpc", outpc, 0);
      chk("rst_outinsn", outinsn, 0);
      chk("rst_reqs", {rd_req, wr_req}, 0);
      chk("rst_wr_be", wr_be, 0);
      chk("rst_outstall", outstall, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Non-memory instruction passes the earlier writeback through.
      pc         = 32'h80;
      insn       = 32'hE081_2003;
      inbubble   = 1'b0;
      write_reg  = 1'b1;
      write_num  = 4'd7;
      write_data = 32'h77;
      push_wb(4'd7, 32'h77);
      @(posedge clk);
      #1;
      chk("pass_outbubble", outbubble, 0);
      chk("pass_outpc", outpc, 32'h80);
      inbubble  = 1'b1;
      insn      = 32'h0;
      write_reg = 1'b0;
      @(posedge clk);
      #1;
      chk("bubble_outbubble", outbubble, 1);

      // LDR r1,[r2,#4]
      rd_fix = 32'hAABB_CCDD;
      push_beat(32'h104, 1'b0, 4'h0, 32'h0, 4'd0);
      push_wb(4'd1, 32'hAABB_CCDD);
      run_insn(32'hE592_1004, 32'h100, 32'h4, 0, st);
      chk("ldr_stalls", st, 0);
      chk("ldr_outbubble", outbubble, 0);
      chk("ldr_outinsn", outinsn, 32'hE592_1004);

      // LDRB r3,[r4,#3] at 0x103
      rd_fix = 32'h1122_3344;
      push_beat(32'h100, 1'b0, 4'h0, 32'h0, 4'd0);
      push_wb(4'd3, 32'h0000_0011);
      run_insn(32'hE5D4_3003, 32'h100, 32'h3, 0, st);
      chk("ldrb_stalls", st, 0);

      // STRB r5,[r6,#2] at 0x102
      push_beat(32'h100, 1'b1, 4'b0100, 32'h5A5A_5A5A, 4'd5);
      run_insn(32'hE5C6_5002, 32'h100, 32'h2, 0, st);
      chk("strb_stalls", st, 0);

      // STMDB r13!,{r0,r4,r15}
      push_beat(32'h1F4, 1'b1, 4'hF, 32'hC0DE_0000, 4'd0);
      push_beat(32'h1F8, 1'b1, 4'hF, 32'hC0DE_0004, 4'd4);
      push_beat(32'h1FC, 1'b1, 4'hF, 32'hC0DE_000F, 4'd15);
      push_wb(4'd13, 32'h1F4);
      run_insn(32'hE92D_8011, 32'h200, 32'h0, 0, st);
      chk("stmdb_stalls", st, 3);
      chk("stmdb_outbubble", outbubble, 0);

      // LDMIA r7,{r3,r5} with two wait cycles on the first beat
      rd_mode = 1'b1;
      push_beat(32'h100, 1'b0, 4'h0, 32'h0, 4'd0);
      push_beat(32'h104, 1'b0, 4'h0, 32'h0, 4'd0);
      push_wb(4'd3, 32'hD000_0100);
      push_wb(4'd5, 32'hD000_0104);
      run_insn(32'hE897_0028, 32'h100, 32'h0, 2, st);
      chk("ldmia_wait_stalls", st, 3);

      // LDR r1,[r2],#8 (post-index writes base)
      push_beat(32'h300, 1'b0, 4'h0, 32'h0, 4'd0);
      push_wb(4'd1, 32'hD000_0300);
      push_wb(4'd2, 32'h308);
      run_insn(32'hE492_1008, 32'h300, 32'h8, 0, st);
      chk("ldr_post_stalls", st, 1);

      // STR r6,[r9,#-4]! from 0 wraps to 0xFFFFFFFC
      push_beat(32'hFFFF_FFFC, 1'b1, 4'hF, 32'hC0DE_0006, 4'd6);
      push_wb(4'd9, 32'hFFFF_FFFC);
      run_insn(32'hE529_6004, 32'h0, 32'h4, 0, st);
      chk("str_wrap_stalls", st, 1);

      // LDR r2,[r2,#4]! : loaded value wins over base writeback
      push_beat(32'h504, 1'b0, 4'h0, 32'h0, 4'd0);
      push_wb(4'd2, 32'hD000_0504);
      run_insn(32'hE5B2_2004, 32'h500, 32'h4, 0, st);
      chk("ldr_rdrn_stalls", st, 1);

      // LDMIA r8!,{} : no beats, base rewritten unchanged
      push_wb(4'd8, 32'h400);
      run_insn(32'hE8B8_0000, 32'h400, 32'h0, 0, st);
      chk("ldm_empty_stalls", st, 0);

      repeat (3) @(posedge clk);
      #1;

      // Reset during beat 2 of a 4-beat LDMIA r1,{r4-r7}
      push_beat(32'h600, 1'b0, 4'h0, 32'h0, 4'd0);
      push_beat(32'h604, 1'b0, 4'h0, 32'h0, 4'd0);
      push_wb(4'd4, 32'hD000_0600);
      pc       = pc + 4;
      insn     = 32'hE891_00F0;
      op0      = 32'h600;
      op1      = 32'h0;
      inbubble = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      rst      = 1'b1;
      inbubble = 1'b1;
      insn     = 32'h0;
      #1;
      chk("midrst_outbubble", outbubble, 1);
      chk("midrst_out_write_reg", out_write_reg, 0);
      chk("midrst_outstall", outstall, 0);
      chk("midrst_reqs", {rd_req, wr_req}, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      rd_mode = 1'b0;
      rd_fix  = 32'hAABB_CCDD;
      push_beat(32'h104, 1'b0, 4'h0, 32'h0, 4'd0);
      push_wb(4'd1, 32'hAABB_CCDD);
      run_insn(32'hE592_1004, 32'h100, 32'h4, 0, st);
      chk("post_rst_ldr_stalls", st, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("wq_drained", wq.size(), 0);
      chk("bq_drained", bq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
